// File: rtl/boot_loader.sv
// Byte-serial program loader: receives a word count, 2N data bytes (high byte
// first) and an XOR checksum, writes program memory, and releases the core only
// after a verified image.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for the header byte (word count N)
// HI     | waiting for the high byte of the next word
// LO     | waiting for the low byte; its acceptance triggers the write
// CHK    | waiting for the checksum byte
// DONE   | image verified, core released
// ERR    | bad header, bad checksum or inter-byte timeout; core held
module boot_loader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 32,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   words_inc;
  logic [7:0]        hi_byte;
  logic [7:0]        chksum;
  logic [TMR_W-1:0]  tmr;
  logic              accept;
  logic              hdr_ok;
  logic              last_word;
  logic              in_load;
  logic              tmr_expire;

  assign words_inc = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    in_ready   = 1'b0;
    in_load    = 1'b0;
    accept     = 1'b0;
    hdr_ok     = 1'b0;
    last_word  = 1'b0;
    tmr_expire = 1'b0;
    state_nxt  = state;

    in_ready  = (state != S_DONE) && (state != S_ERR);
    in_load   = (state == S_HI) || (state == S_LO) || (state == S_CHK);
    accept    = in_valid && in_ready;
    hdr_ok    = (in_data != 8'd0) && (int'(in_data) <= DEPTH);
    last_word = (words_inc == word_cnt);
    // Idle cycles are counted up to the limit; the limit-th idle cycle aborts.
    tmr_expire = in_load && !accept && (tmr == TMR_W'(TIMEOUT_CYC - 1));

    case (state)
      S_IDLE:  if (accept) state_nxt = hdr_ok ? S_HI : S_ERR;
      S_HI:    if (accept) state_nxt = S_LO;
      S_LO:    if (accept) state_nxt = last_word ? S_CHK : S_HI;
      S_CHK:   if (accept) state_nxt = (in_data == chksum) ? S_DONE : S_ERR;
      S_DONE:  if (reload) state_nxt = S_IDLE;
      S_ERR:   if (reload) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (tmr_expire) state_nxt = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      word_cnt     <= '0;
      hi_byte      <= '0;
      chksum       <= '0;
      tmr          <= '0;
    end else begin
      mem_we   <= 1'b0;
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
      cpu_hold <= (state_nxt != S_DONE);
      tmr      <= (in_load && !accept && !tmr_expire) ? tmr + TMR_W'(1) : '0;

      if (accept) begin
        case (state)
          S_IDLE: begin
            if (hdr_ok) begin
              word_cnt     <= in_data[ADDR_W:0];
              chksum       <= '0;
              words_loaded <= '0;
            end
          end
          S_HI: begin
            hi_byte <= in_data;
            chksum  <= chksum ^ in_data;
          end
          S_LO: begin
            // Address is the pre-increment count; the count bumps alongside the strobe.
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= DATA_W'({hi_byte, in_data});
            words_loaded <= words_inc;
            chksum       <= chksum ^ in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed images plus randomized images
// with random inter-byte gaps, checked against an image-level reference model.
module tb_boot_loader;

  localparam int TO = 1000;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [5:0]  words_loaded;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  img [64];
  logic [4:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      reload   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reload   = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, ".rl_ready"}, in_ready, 1);
    chk({tag, ".rl_done"},  done,     0);
    chk({tag, ".rl_err"},   err,      0);
    chk({tag, ".rl_hold"},  cpu_hold, 1);
  endtask

  // Model: a header of 1..32 yields N writes of {img[2i],img[2i+1]} at address i;
  // the image is accepted iff the trailing byte equals the XOR of the 2N data bytes.
  task automatic run_load(input string tag, input logic [7:0] hdr,
                          input logic [7:0] cbyte, input int max_gap);
    int n;
    logic [7:0] x;
    logic good;
    wr_addr_q.delete();
    wr_data_q.delete();
    n = int'(hdr);
    send(hdr, max_gap);
    if (n < 1 || n > 32) begin
      repeat (2) @(negedge clk);
      chk({tag, ".err"},     err,      1);
      chk({tag, ".done"},    done,     0);
      chk({tag, ".hold"},    cpu_hold, 1);
      chk({tag, ".ready"},   in_ready, 0);
      chk({tag, ".nwrites"}, wr_addr_q.size(), 0);
      return;
    end
    chk({tag, ".hold_hdr"}, cpu_hold, 1);
    chk({tag, ".done_hdr"}, done,     0);
    x = 8'h00;
    for (int i = 0; i < 2 * n; i++) begin
      send(img[i], max_gap);
      x = x ^ img[i];
    end
    chk({tag, ".hold_data"}, cpu_hold, 1);
    send(cbyte, max_gap);
    good = (cbyte == x);
    chk({tag, ".nwrites"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), wr_addr_q[i], i);
      chk($sformatf("%s.data%0d", tag, i), wr_data_q[i], {img[2*i], img[2*i+1]});
    end
    chk({tag, ".done"},  done,         good);
    chk({tag, ".err"},   err,          !good);
    chk({tag, ".hold"},  cpu_hold,     !good);
    chk({tag, ".words"}, words_loaded, n);
    chk({tag, ".ready"}, in_ready,     0);
  endtask

  initial begin
    logic [7:0] x;
    int n;
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    reload   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst.ready", in_ready,     1);
    chk("rst.we",    mem_we,       0);
    chk("rst.addr",  mem_addr,     0);
    chk("rst.wdata", mem_wdata,    0);
    chk("rst.hold",  cpu_hold,     1);
    chk("rst.done",  done,         0);
    chk("rst.err",   err,          0);
    chk("rst.words", words_loaded, 0);
    rst = 1'b1;
    @(negedge clk);

    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'hAB; img[3] = 8'hCD;
    run_load("n2", 8'd2, 8'h40, 0);
    do_reload("n2");

    img[0] = 8'h5A; img[1] = 8'hA5;
    run_load("n1ok", 8'd1, 8'hFF, 0);
    do_reload("n1ok");

    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      img[i] = 8'($urandom);
      x = x ^ img[i];
    end
    run_load("n32", 8'd32, x, 0);
    do_reload("n32");

    img[0] = 8'h00; img[1] = 8'hFF;
    run_load("badchk", 8'd1, 8'h00, 0);
    do_reload("badchk");

    run_load("hdr0", 8'h00, 8'h00, 0);
    do_reload("hdr0");
    run_load("hdr21", 8'h21, 8'h00, 0);
    do_reload("hdr21");
    run_load("hdrbig", 8'($urandom_range(34, 255)), 8'h00, 0);
    do_reload("hdrbig");

    // Timeout: stall after three data bytes of a three-word image.
    send(8'd3, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    repeat (TO - 1) @(negedge clk);
    chk("tmo.err_before", err, 0);
    chk("tmo.ready_before", in_ready, 1);
    @(negedge clk);
    chk("tmo.err",   err,      1);
    chk("tmo.hold",  cpu_hold, 1);
    chk("tmo.ready", in_ready, 0);
    do_reload("tmo");

    // Reset while waiting for a high byte, after one word has been written.
    send(8'd3, 0);
    send(8'hC3, 0);
    send(8'h3C, 0);
    chk("rsthi.words_pre", words_loaded, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rsthi.ready", in_ready,     1);
    chk("rsthi.we",    mem_we,       0);
    chk("rsthi.addr",  mem_addr,     0);
    chk("rsthi.wdata", mem_wdata,    0);
    chk("rsthi.hold",  cpu_hold,     1);
    chk("rsthi.done",  done,         0);
    chk("rsthi.err",   err,          0);
    chk("rsthi.words", words_loaded, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 32));
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        img[i] = 8'($urandom);
        x = x ^ img[i];
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
      run_load($sformatf("rnd%0d", k), 8'(n), x, 3);
      do_reload($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
